// File: rtl/fifo_mem.sv
// Storage array for the fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Single-clock first-word fall-through FIFO with valid/ready on both sides,
// transfer strobes and almost-full/almost-empty flags derived from the occupancy count.
module fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             wr_en,
    output logic             rd_en,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_data;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign wr_en     = in_valid & in_ready;
    assign rd_en     = out_valid & out_ready;
    assign out_data  = out_valid ? head_data : '0;

    // Signed compare keeps the flags sane even if a margin exceeds DEPTH.
    assign almost_full  = int'(count_q) >= (int'(DEPTH) - int'(AF_MARGIN));
    assign almost_empty = int'(count_q) <= int'(AE_MARGIN);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Reset is active-high despite the name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en & ~rst_n),
        .wr_addr(wr_ptr_q),
        .wr_data(in_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head_data)
    );

endmodule

// File: tb/tb_fifo.sv
// Directed vector table plus queue-checked sequences for the fifo.
module tb_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             wr_en;
    logic             rd_en;
    logic             almost_full;
    logic             almost_empty;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [WIDTH-1:0] q[$];

    always #5 clk = ~clk;

    fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_MARGIN(2),
        .AE_MARGIN(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_wr;
        logic       e_rd;
        logic       e_af;
        logic       e_ae;
    } vec_t;

    vec_t vecs[14];

    // Outputs are sampled at the falling edge, state advances at the rising edge.
    task automatic check(input string name, input logic ir, input logic ov,
                         input logic [7:0] od, input logic wr, input logic rd,
                         input logic af, input logic ae);
        logic [13:0] act, exp;
        act = {in_ready, out_valid, out_data, wr_en, rd_en, almost_full, almost_empty};
        exp = {ir, ov, od, wr, rd, af, ae};
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got ir=%b ov=%b od=%h wr=%b rd=%b af=%b ae=%b, want ir=%b ov=%b od=%h wr=%b rd=%b af=%b ae=%b",
                     name, in_ready, out_valid, out_data, wr_en, rd_en, almost_full,
                     almost_empty, ir, ov, od, wr, rd, af, ae);
        end
    endtask

    // One clock with the queue model predicting every output.
    task automatic cycle(input string name, input logic rst, input logic iv,
                         input logic [7:0] d, input logic ordy);
        int   cnt;
        logic e_ir, e_ov, e_wr, e_rd;
        logic [7:0] e_od;
        rst_n = rst; in_valid = iv; in_data = d; out_ready = ordy;
        cnt  = q.size();
        e_ir = (cnt != DEPTH);
        e_ov = (cnt != 0);
        e_od = e_ov ? q[0] : 8'h00;
        e_wr = iv && e_ir;
        e_rd = e_ov && ordy;
        @(negedge clk);
        check(name, e_ir, e_ov, e_od, e_wr, e_rd, cnt >= DEPTH - 2, cnt <= 2);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (e_rd) void'(q.pop_front());
            if (e_wr) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                  vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_af, vecs[i].e_ae);
            @(posedge clk);
            #1;
        end
        q.delete();

        // Fill to full, then a refused write, then a read from full.
        for (int i = 0; i < DEPTH; i++) cycle($sformatf("fill%0d", i), 1'b0, 1'b1, 8'(i), 1'b0);
        cycle("full_refuse", 1'b0, 1'b1, 8'hFF, 1'b0);
        cycle("full_read_no_write", 1'b0, 1'b1, 8'hEE, 1'b1);
        cycle("ready_after_read", 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i < DEPTH; i++) cycle($sformatf("drain%0d", i), 1'b0, 1'b0, 8'h00, 1'b1);
        cycle("drained", 1'b0, 1'b0, 8'h00, 1'b0);

        // Half full with continuous simultaneous traffic so pointers wrap.
        for (int i = 0; i < 8; i++) cycle("wrap_fill", 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle($sformatf("wrap%0d", i), 1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
        for (int i = 0; i < 8; i++) cycle("wrap_drain", 1'b0, 1'b0, 8'h00, 1'b1);
        cycle("wrap_empty", 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            cycle($sformatf("rand%0d", i), (i == 500) || (i == 501),
                  1'($urandom_range(0, 99) < 60), 8'($urandom),
                  1'($urandom_range(0, 99) < 45));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
